// File: rtl/krypton_vga_timing.sv
// Krypton VGA timing generator and output stage.
// Produces the pixel H/V counters for the tile-video stage, delays the raw
// sync/blank decode to match that stage's latency, and registers the final
// hsync/vsync/RGB pins. Everything advances only on i_Pix_En strobes.
module krypton_vga_timing #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 2,
   parameter bit SYNC_POL   = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Pix_En,
   input  logic [8:0] i_color,
   output logic [9:0] o_HCounter,
   output logic [9:0] o_VCounter,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic [2:0] o_red,
   output logic [2:0] o_green,
   output logic [2:0] o_blue,
   output logic       o_active,
   output logic       o_line_start,
   output logic       o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counters are 10 bits wide, so a frame larger than 1024x1024 cannot be counted.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("krypton_vga_timing: H_TOTAL and V_TOTAL must be <= 1024");
   end
   if (PIPE_DELAY < 1 || PIPE_DELAY > 7) begin : g_bad_delay
      $error("krypton_vga_timing: PIPE_DELAY must be 1..7");
   end

   // Decode boundaries kept 11 bits wide so an end bound of exactly 1024 does not wrap.
   localparam logic [9:0]  L_H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  L_V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] L_H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] L_V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] L_HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] L_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] L_VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] L_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]            r_h;
   logic [9:0]            r_v;
   logic [PIPE_DELAY-1:0] r_act_dly;
   logic [PIPE_DELAY-1:0] r_hs_dly;
   logic [PIPE_DELAY-1:0] r_vs_dly;
   logic                  r_hsync;
   logic                  r_vsync;
   logic [8:0]            r_rgb;
   logic                  r_active;
   logic                  r_line_start;
   logic                  r_frame_start;

   logic [10:0] w_h_ext;
   logic [10:0] w_v_ext;
   logic        w_h_wrap;
   logic        w_v_wrap;
   logic        w_act;
   logic        w_hs;
   logic        w_vs;

   // Raw decode of the current counter position (sync flags are "asserted", not pin level).
   always_comb begin
      w_h_ext  = {1'b0, r_h};
      w_v_ext  = {1'b0, r_v};
      w_h_wrap = (r_h == L_H_LAST);
      w_v_wrap = (r_v == L_V_LAST);
      w_act    = (w_h_ext < L_H_ACT) && (w_v_ext < L_V_ACT);
      w_hs     = (w_h_ext >= L_HS_BEG) && (w_h_ext < L_HS_END);
      w_vs     = (w_v_ext >= L_VS_BEG) && (w_v_ext < L_VS_END);
   end

   // Horizontal/vertical pixel counters; V steps once per H wrap.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (i_Pix_En) begin
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= w_v_wrap ? 10'd0 : r_v + 10'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   // Delay line that lines the decode up with the colour returning from the video stage.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_act_dly <= '0;
         r_hs_dly  <= '0;
         r_vs_dly  <= '0;
      end else if (i_Pix_En) begin
         r_act_dly[0] <= w_act;
         r_hs_dly[0]  <= w_hs;
         r_vs_dly[0]  <= w_vs;
         for (int i = 1; i < PIPE_DELAY; i++) begin
            r_act_dly[i] <= r_act_dly[i-1];
            r_hs_dly[i]  <= r_hs_dly[i-1];
            r_vs_dly[i]  <= r_vs_dly[i-1];
         end
      end
   end

   // Pin register: tail of the delay line plus the colour sampled on the same strobe.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_hsync  <= ~SYNC_POL;
         r_vsync  <= ~SYNC_POL;
         r_rgb    <= '0;
         r_active <= 1'b0;
      end else if (i_Pix_En) begin
         r_active <= r_act_dly[PIPE_DELAY-1];
         r_hsync  <= r_hs_dly[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
         r_vsync  <= r_vs_dly[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
         r_rgb    <= r_act_dly[PIPE_DELAY-1] ? i_color : 9'd0;
      end
   end

   // One-clock line/frame pulses; cleared every clock so they never stretch between strobes.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= i_Pix_En && w_h_wrap;
         r_frame_start <= i_Pix_En && w_h_wrap && w_v_wrap;
      end
   end

   assign o_HCounter    = r_h;
   assign o_VCounter    = r_v;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_red         = r_rgb[8:6];
   assign o_green       = r_rgb[5:3];
   assign o_blue        = r_rgb[2:0];
   assign o_active      = r_active;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;

endmodule

// File: doc/krypton_vga_timing.md
Name: krypton_vga_timing

Overview:
- Pixel timing generator and VGA output stage for the Krypton text display.
- Produces the 10-bit horizontal/vertical pixel counters that drive the tile-video stage.
- Takes that stage's 9-bit RGB333 colour back, delays sync and blanking to match the video pipeline latency, and drives registered hsync/vsync/RGB to the pins.
- Pixel rate is set by a clock-enable strobe, so the block runs from the system clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines (V_TOTAL = 525)
- PIPE_DELAY, 2, pixel strobes between a counter value and its colour arriving on i_color (1..7)
- SYNC_POL, 0, sync active level: 0 = active low, 1 = active high

Ports:
- i_Clk  input  1  system clock
- i_Reset  input  1  synchronous active-high reset
- i_Pix_En  input  1  pixel strobe; all state advances only on clocks where it is high
- i_color  input  9  RGB333 from the video stage, {R[8:6],G[5:3],B[2:0]}
- o_HCounter  output  10  current horizontal count, 0..H_TOTAL-1
- o_VCounter  output  10  current vertical count, 0..V_TOTAL-1
- o_hsync  output  1  registered, pipeline-aligned horizontal sync
- o_vsync  output  1  registered, pipeline-aligned vertical sync
- o_red  output  3  registered red, forced 0 outside the active area
- o_green  output  3  registered green, forced 0 outside the active area
- o_blue  output  3  registered blue, forced 0 outside the active area
- o_active  output  1  registered, pipeline-aligned active-area flag
- o_line_start  output  1  one-clock pulse when the H counter wraps to 0
- o_frame_start  output  1  one-clock pulse when both counters wrap to (0,0)

Behaviour:
- Reset (i_Reset high at the clock edge): takes priority over i_Pix_En; applies mid-frame identically. After the edge:
  - H = 0 and V = 0.
  - All delay-line stages hold sync deasserted (~SYNC_POL) and active = 0.
  - o_hsync = o_vsync = ~SYNC_POL.
  - o_red = o_green = o_blue = 0.
  - o_active, o_line_start and o_frame_start = 0.
- Counters: o_HCounter/o_VCounter come directly from the counter registers.
  - On a clock with i_Pix_En high: H increments.
  - At H == H_TOTAL-1, H goes to 0 and V increments.
  - At V == V_TOTAL-1 with an H wrap, V goes to 0.
  - With i_Pix_En low, everything holds, including the delay line and output registers.
- Raw decode from the current H/V:
  - active = (H < H_ACTIVE) && (V < V_ACTIVE).
  - hs = H_ACTIVE+H_FP <= H < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs = V_ACTIVE+V_FP <= V < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Sync is evaluated per pixel; vsync edges therefore align with H = 0 of the line, not with hsync.
- Delay line: a PIPE_DELAY-deep shift register of {active, hs, vs}, shifting only on strobes.
- Output register, on each strobe:
  - Loads the delay-line tail: o_active, and o_hsync/o_vsync = SYNC_POL when asserted, else ~SYNC_POL.
  - Loads RGB = i_color fields if the tail active bit is 1, else 0.
  - Net effect: after strobe n, the outputs describe the counter value present PIPE_DELAY strobes before strobe n, paired with the i_color sampled at strobe n.
- Pulses:
  - o_line_start goes high for exactly one i_Clk cycle after a strobe that moves H from H_TOTAL-1 to 0.
  - o_frame_start goes high for exactly one i_Clk cycle after a strobe that moves (H,V) from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Neither pulse is generated by reset itself.
- Continuous i_Pix_En gives one pixel per clock. There is no skid or backpressure; the consumer must tolerate any strobe spacing.
- Widths: counters are 10-bit. H_TOTAL and V_TOTAL must be ≤ 1024 (elaboration-time check).

Test Plan:
- Reset, then i_Pix_En held high for 800 clocks -> o_HCounter runs 0..799 and wraps to 0, o_VCounter goes 0->1, o_line_start pulses once (cycle after the wrap); with SYNC_POL=0, o_hsync is low for exactly 96 strobes, first low at the strobe that is 2 strobes after H=656.
- Run a full frame of 420000 strobes -> o_vsync low for exactly 1600 strobes (V=490..491), o_frame_start pulses once per frame, two consecutive pulses are 420000 clocks apart.
- i_Pix_En high 1 clock in 4 -> counters, syncs and RGB change only on strobe cycles; line period = 3200 clocks; o_line_start stays 1 clock wide.
- Drive i_color = {V[2:0],H[2:0],3'b101}, computed from the counters PIPE_DELAY strobes earlier -> each output pixel matches its own coordinate; RGB = 0 whenever o_active = 0 (e.g. H = 640..799 delayed).
- Assert i_Reset for 1 clock at H=300, V=200 -> next cycle H=V=0, syncs deasserted, RGB=0, no o_frame_start; timing then resumes from (0,0).
- SYNC_POL=1, PIPE_DELAY=3 -> syncs idle low and pulse high; alignment shifts by exactly one extra strobe versus the default.
